rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Sequences the register file's single write port between two writeback sources.
//  Port A is the pipeline writeback stage and can be backpressured. Port B is the
//  memory/cache fill return; it cannot be stalled and is queued in a small FIFO.
//  Also keeps a per-register outstanding-write scoreboard that decode uses for stalls.
// PARAMETERS
//  FIFO_DEPTH  2   B-queue entries; power of two, >=2
//  MAX_WAIT    3   consecutive cycles the B head may lose before B is force-granted
//  DW          16  data width
//  RW          4   register index width (16 registers; R0 hardwired zero)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      synchronous active-low reset
//  a_valid        in   1      A write request
//  a_ready        out  1      A accepted this cycle (combinational grant)
//  a_reg          in   RW     A destination
//  a_data         in   DW     A write data
//  a_mode         in   2      00 full, 01 LLB, 10 LHB, 11 treated as full
//  b_valid        in   1      B push (no backpressure)
//  b_reg/b_data/b_mode  in  RW/DW/2  B destination, data, mode
//  b_full         out  1      B FIFO full (registered)
//  sb_set_valid   in   1      decode issued a writer of sb_set_reg
//  sb_set_reg     in   RW     register gaining an outstanding write
//  src1_reg, src2_reg  in  RW  decode source registers
//  hazard1, hazard2    out  1  source has an outstanding write (combinational)
//  rf_write_reg   out  1      register-file write enable (registered)
//  rf_dst_reg     out  RW     register-file destination (registered)
//  rf_writedata   out  DW     register-file write data (registered)
//  rf_llb, rf_lhb out  1      register-file byte-mode strobes, one-hot or both 0
//  err            out  1      sticky: B push while full, or scoreboard overflow
// BEHAVIOUR
//  - Reset, synchronous on rst_n=0 at posedge clk:
//    - Clears all rf_* outputs, err and the FIFO. b_full=0.
//    - Clears the scoreboard counters and wait_cnt. FSM goes to A_PRI.
//    - Reset during a grant drops that write.
//  - Grant, one per cycle:
//    - In A_PRI: grant A if a_valid, else grant the B head if the FIFO is non-empty.
//    - In B_FORCE: grant the B head. a_ready=0.
//  - FSM: A_PRI -> B_FORCE at the end of a cycle when the FIFO is non-empty, B is not
//    granted, and (wait_cnt==MAX_WAIT-1 or FIFO full). B_FORCE -> A_PRI after a B grant.
//  - wait_cnt: +1 per cycle the head waits ungranted; cleared on B grant or when the FIFO is empty.
//  - Latency:
//    - A: grant at cycle N -> rf_write_reg=1 at N+1.
//    - B: a push at N is visible as head at N+1, so the earliest write is at N+2.
//  - FIFO:
//    - Push while full with a pop in the same cycle is accepted.
//    - Push while full without a pop is dropped and sets err.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - R0 (reg==0): the request is granted and popped, but rf_write_reg stays 0. The
//    scoreboard never counts R0.
//  - Modes: 01 -> rf_llb=1; 10 -> rf_lhb=1; 00 and 11 -> both 0. Data is passed unchanged.
//  - Scoreboard: 2-bit counter per register.
//    - Increments on sb_set_valid; decrements on the cycle the rf write commits.
//    - Increment and decrement in the same cycle leave it unchanged.
//    - Increment at 3 holds the value and sets err. A decrement at 0 is ignored.
//    - hazardN = (srcN_reg!=0) && cnt[srcN_reg]!=0; a commit this cycle is not bypassed.
// CONFIGURATION
//  RF_WB_STATS_EN defined:
//    - Adds output stat_conflicts[15:0], reset 0.
//    - Counts +1 per cycle with a_valid=1 and the FIFO non-empty; saturates at 16'hFFFF.
//  RF_WB_STATS_EN undefined: the port and the counter are absent; all else identical.
// STRUCTURE
//  - Shared package rf_wb_pkg:
//    - Mode encodings (WB_FULL/WB_LLB/WB_LHB).
//    - FSM state enum (A_PRI, B_FORCE).
//    - DW/RW constants.
//  - One sub-module, rf_wb_fifo: a synchronous FIFO holding {reg, mode, data},
//    with full/empty flags.
//  - The arbiter FSM, wait counter, scoreboard and output register stay in this block.
// TESTING
//  - Reset: rst_n=0 for 2 cycles mid-traffic -> all rf_* outputs 0, b_full=0,
//    hazards 0, err 0.
//  - A only: a_valid=1, a_reg=5, a_data=16'h1234, a_mode=00 -> a_ready=1;
//    next cycle rf_write_reg=1, rf_dst_reg=5, rf_writedata=16'h1234.
//  - Starvation: a_valid held at 1, one B push (reg 7) -> A is granted 3 cycles, then
//    a_ready=0 for one cycle and R7 is written; A resumes the following cycle.
//  - Overflow: FIFO_DEPTH=2, a_valid=1 held, three B pushes on back-to-back cycles ->
//    b_full=1 after the second push, and B is force-granted. Expected outcome for the
//    third push depends on pop timing:
//    - A pop in the same cycle -> push accepted.
//    - No pop -> push dropped and err=1.
//  - Scoreboard: sb_set R3 twice -> hazard1 on src1_reg=3 stays high until two R3
//    commits. R0 write with LLB -> rf_write_reg=0 and no hazard.
//  - Stats (RF_WB_STATS_EN): 4 cycles of a_valid with the FIFO non-empty ->
//    stat_conflicts=4.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: mode encodings,
// arbiter state and default widths.
package rf_wb_pkg;

  localparam int WB_DW = 16;
  localparam int WB_RW = 4;

  localparam logic [1:0] WB_FULL = 2'b00;
  localparam logic [1:0] WB_LLB  = 2'b01;
  localparam logic [1:0] WB_LHB  = 2'b10;

  typedef enum logic {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for the non-stallable B writeback stream.
// The head is read combinationally so a push becomes visible on the next cycle.
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (PW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (A) and
// queued fill returns (B), with an outstanding-write scoreboard. Optional RF_WB_STATS_EN.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 3,
  parameter int DW         = WB_DW,
  parameter int RW         = WB_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [RW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic [1:0]    a_mode,
  input  logic          b_valid,
  input  logic [RW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  input  logic [1:0]    b_mode,
  output logic          b_full,
  input  logic          sb_set_valid,
  input  logic [RW-1:0] sb_set_reg,
  input  logic [RW-1:0] src1_reg,
  input  logic [RW-1:0] src2_reg,
  output logic          hazard1,
  output logic          hazard2,
  output logic          rf_write_reg,
  output logic [RW-1:0] rf_dst_reg,
  output logic [DW-1:0] rf_writedata,
  output logic          rf_llb,
  output logic          rf_lhb,
  output logic          err
`ifdef RF_WB_STATS_EN
  , output logic [15:0] stat_conflicts
`endif
);

  localparam int EW   = RW + 2 + DW;
  localparam int WW   = $clog2(MAX_WAIT + 1);
  localparam int NREG = 1 << RW;

  arb_state_t       state_reg;
  logic [WW-1:0]    wait_cnt_reg;
  logic [EW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_overflow;
  logic             grant_a;
  logic             grant_b;
  logic             grant;
  logic             to_force;
  logic [RW-1:0]    sel_reg;
  logic [1:0]       sel_mode;
  logic [DW-1:0]    sel_data;
  logic             sel_write;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  sb_ovf;

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_valid),
    .push_data ({b_reg, b_mode, b_data}),
    .pop       (grant_b),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  assign b_full = fifo_full;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_reg)
      A_PRI: begin
        if (a_valid)          grant_a = 1'b1;
        else if (!fifo_empty) grant_b = 1'b1;
      end
      B_FORCE: grant_b = !fifo_empty;
      default: ;
    endcase
  end

  assign a_ready = grant_a;
  assign grant   = grant_a || grant_b;

  always_comb begin
    sel_reg  = a_reg;
    sel_mode = a_mode;
    sel_data = a_data;
    if (grant_b) begin
      {sel_reg, sel_mode, sel_data} = head;
    end
  end

  // R0 requests are consumed but never reach the register file.
  assign sel_write = grant && (sel_reg != '0);

  assign to_force = (state_reg == A_PRI) && !fifo_empty && !grant_b &&
                    ((wait_cnt_reg == WW'(MAX_WAIT - 1)) || fifo_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= A_PRI;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        A_PRI:   if (to_force) state_reg <= B_FORCE;
        B_FORCE: if (grant_b)  state_reg <= A_PRI;
        default: state_reg <= A_PRI;
      endcase
      if (fifo_empty || grant_b) wait_cnt_reg <= '0;
      else                       wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_write_reg <= 1'b0;
      rf_dst_reg   <= '0;
      rf_writedata <= '0;
      rf_llb       <= 1'b0;
      rf_lhb       <= 1'b0;
    end else begin
      rf_write_reg <= sel_write;
      rf_llb       <= sel_write && (sel_mode == WB_LLB);
      rf_lhb       <= sel_write && (sel_mode == WB_LHB);
      if (grant) begin
        rf_dst_reg   <= sel_reg;
        rf_writedata <= sel_data;
      end
    end
  end

  // One saturating outstanding-write counter per register; R0 is never tracked.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_r0
        assign busy[gi]   = 1'b0;
        assign sb_ovf[gi] = 1'b0;
      end else begin : g_cnt
        logic [1:0] cnt_reg;
        logic       inc;
        logic       dec;
        assign inc        = sb_set_valid && (sb_set_reg == RW'(gi));
        assign dec        = rf_write_reg && (rf_dst_reg == RW'(gi));
        assign busy[gi]   = (cnt_reg != 2'd0);
        assign sb_ovf[gi] = inc && !dec && (cnt_reg == 2'd3);
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            cnt_reg <= 2'd0;
          end else if (inc && !dec) begin
            if (cnt_reg != 2'd3) cnt_reg <= cnt_reg + 2'd1;
          end else if (dec && !inc) begin
            if (cnt_reg != 2'd0) cnt_reg <= cnt_reg - 2'd1;
          end
        end
      end
    end
  endgenerate

  assign hazard1 = (src1_reg != '0) && busy[src1_reg];
  assign hazard2 = (src2_reg != '0) && busy[src2_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (fifo_overflow || (|sb_ovf)) err <= 1'b1;
  end

`ifdef RF_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
    end else if (a_valid && !fifo_empty && (stat_conflicts != 16'hFFFF)) begin
      stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: table of A-only writes plus hand-built
// sequences for starvation, FIFO overflow, scoreboard and reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic [1:0]  a_mode;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic [1:0]  b_mode;
  logic        b_full;
  logic        sb_set_valid;
  logic [3:0]  sb_set_reg;
  logic [3:0]  src1_reg;
  logic [3:0]  src2_reg;
  logic        hazard1;
  logic        hazard2;
  logic        rf_write_reg;
  logic [3:0]  rf_dst_reg;
  logic [15:0] rf_writedata;
  logic        rf_llb;
  logic        rf_lhb;
  logic        err;
`ifdef RF_WB_STATS_EN
  logic [15:0] stat_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .a_mode       (a_mode),
    .b_valid      (b_valid),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .b_mode       (b_mode),
    .b_full       (b_full),
    .sb_set_valid (sb_set_valid),
    .sb_set_reg   (sb_set_reg),
    .src1_reg     (src1_reg),
    .src2_reg     (src2_reg),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .rf_write_reg (rf_write_reg),
    .rf_dst_reg   (rf_dst_reg),
    .rf_writedata (rf_writedata),
    .rf_llb       (rf_llb),
    .rf_lhb       (rf_lhb),
    .err          (err)
`ifdef RF_WB_STATS_EN
    , .stat_conflicts (stat_conflicts)
`endif
  );

  typedef struct {
    logic        av;
    logic [3:0]  r;
    logic [15:0] d;
    logic [1:0]  m;
    logic        exp_ready;
    logic        exp_we;
    logic        exp_llb;
    logic        exp_lhb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_valid = 0; a_reg = 0; a_data = 0; a_mode = 0;
    b_valid = 0; b_reg = 0; b_data = 0; b_mode = 0;
    sb_set_valid = 0; sb_set_reg = 0; src1_reg = 0; src2_reg = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic push_b(input logic [3:0] r, input logic [15:0] d);
    b_valid = 1; b_reg = r; b_data = d; b_mode = 2'b00;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd5,  16'h1234, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd9,  16'h00AB, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd2,  16'hCD00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'd15, 16'hFFFF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd0,  16'h5555, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'd4,  16'h7777, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Power-up reset
    do_reset();
    chk("reset_we", rf_write_reg, 0);
    chk("reset_bfull", b_full, 0);
    chk("reset_err", err, 0);

    // A-only table, FIFO empty
    for (int i = 0; i < 6; i++) begin
      a_valid = vecs[i].av; a_reg = vecs[i].r; a_data = vecs[i].d; a_mode = vecs[i].m;
      #1;
      chk($sformatf("vec%0d_ready", i), a_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_we", i), rf_write_reg, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_dst", i), rf_dst_reg, vecs[i].r);
        chk($sformatf("vec%0d_data", i), rf_writedata, vecs[i].d);
        chk($sformatf("vec%0d_llb", i), rf_llb, vecs[i].exp_llb);
        chk($sformatf("vec%0d_lhb", i), rf_lhb, vecs[i].exp_lhb);
      end
    end

    // Starvation: A held, single B push of R7
    a_valid = 1; a_reg = 4'd1; a_data = 16'h0001; a_mode = 2'b00;
    push_b(4'd7, 16'hBEEF);
    #1;
    chk("starve_push_ready", a_ready, 1);
    tick();
    b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("starve_a%0d_ready", i), a_ready, 1);
      tick();
    end
    chk("starve_force_ready", a_ready, 0);
    tick();
    chk("starve_b_we", rf_write_reg, 1);
    chk("starve_b_dst", rf_dst_reg, 7);
    chk("starve_b_data", rf_writedata, 16'hBEEF);
    chk("starve_resume_ready", a_ready, 1);

    // Overflow, third push with no pop: dropped and err
    do_reset();
    a_valid = 1; a_reg = 4'd1; a_data = 16'h0011;
    push_b(4'd8, 16'h0008);
    tick();
    push_b(4'd9, 16'h0009);
    tick();
    chk("ovf1_full", b_full, 1);
    push_b(4'd10, 16'h000A);
    #1;
    chk("ovf1_err_before", err, 0);
    tick();
    b_valid = 0;
    chk("ovf1_err", err, 1);
    chk("ovf1_force_ready", a_ready, 0);
    tick();
    a_valid = 0;
    chk("ovf1_head_dst", rf_dst_reg, 8);
    chk("ovf1_full_after_pop", b_full, 0);
    tick();
    chk("ovf1_second_we", rf_write_reg, 1);
    chk("ovf1_second_dst", rf_dst_reg, 9);
    tick();
    chk("ovf1_dropped_we", rf_write_reg, 0);

    // Overflow, third push coincides with the forced pop: accepted
    do_reset();
    a_valid = 1; a_reg = 4'd1; a_data = 16'h0011;
    push_b(4'd8, 16'h0008);
    tick();
    push_b(4'd9, 16'h0009);
    tick();
    b_valid = 0;
    chk("ovf2_full", b_full, 1);
    tick();
    push_b(4'd10, 16'h000A);
    #1;
    chk("ovf2_force_ready", a_ready, 0);
    tick();
    b_valid = 0;
    a_valid = 0;
    chk("ovf2_head_dst", rf_dst_reg, 8);
    chk("ovf2_full_refill", b_full, 1);
    chk("ovf2_err", err, 0);
    tick();
    chk("ovf2_second_dst", rf_dst_reg, 9);
    tick();
    chk("ovf2_third_we", rf_write_reg, 1);
    chk("ovf2_third_dst", rf_dst_reg, 10);
    chk("ovf2_third_data", rf_writedata, 16'h000A);

    // Scoreboard: two outstanding writes to R3
    do_reset();
    src1_reg = 4'd3;
    sb_set_valid = 1; sb_set_reg = 4'd3;
    #1;
    chk("sb_hz_initial", hazard1, 0);
    tick();
    chk("sb_hz_one", hazard1, 1);
    tick();
    sb_set_valid = 0;
    a_valid = 1; a_reg = 4'd3; a_data = 16'h3333;
    tick();
    a_valid = 0;
    chk("sb_first_commit_we", rf_write_reg, 1);
    chk("sb_hz_during_commit1", hazard1, 1);
    tick();
    chk("sb_hz_after_commit1", hazard1, 1);
    a_valid = 1;
    tick();
    a_valid = 0;
    chk("sb_hz_during_commit2", hazard1, 1);
    tick();
    chk("sb_hz_after_commit2", hazard1, 0);

    // Scoreboard saturation on R4
    src2_reg = 4'd4;
    sb_set_valid = 1; sb_set_reg = 4'd4;
    tick();
    tick();
    tick();
    chk("sb_sat_err_before", err, 0);
    chk("sb_sat_hz2", hazard2, 1);
    tick();
    sb_set_valid = 0;
    chk("sb_sat_err", err, 1);

    // Reset in the middle of traffic clears everything, including the queued B entry
    src1_reg = 4'd2;
    a_valid = 1; a_reg = 4'd5; a_data = 16'h5A5A; a_mode = 2'b01;
    push_b(4'd6, 16'h6666);
    sb_set_valid = 1; sb_set_reg = 4'd2;
    tick();
    b_valid = 0;
    sb_set_valid = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    a_valid = 0;
    #1;
    chk("rst_we", rf_write_reg, 0);
    chk("rst_dst", rf_dst_reg, 0);
    chk("rst_data", rf_writedata, 0);
    chk("rst_llb", rf_llb, 0);
    chk("rst_lhb", rf_lhb, 0);
    chk("rst_bfull", b_full, 0);
    chk("rst_err", err, 0);
    chk("rst_hz1", hazard1, 0);
    chk("rst_hz2", hazard2, 0);
    tick();
    chk("rst_fifo_cleared", rf_write_reg, 0);

`ifdef RF_WB_STATS_EN
    do_reset();
    chk("stats_reset", stat_conflicts, 0);
    push_b(4'd7, 16'h0707);
    tick();
    b_valid = 0;
    a_valid = 1; a_reg = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    a_valid = 0;
    chk("stats_count", stat_conflicts, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
